// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC fetcher feeding a small in-order instruction queue,
// with redirect-driven flush and misaligned-target flagging.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [2:0]  q_count,
    output logic        misalign_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] STALL = 2'd2;
    localparam int         AW    = (QDEPTH == 4) ? 2 : 1;
    localparam logic [2:0] FULL  = 3'(QDEPTH);

    logic [1:0]    state, state_next;
    logic [31:0]   fetch_pc;
    logic [AW-1:0] head, tail;
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic          full, pop, push;
    logic [2:0]    count_next;

    assign imem_addr  = fetch_pc;
    assign out_valid  = q_count != 3'd0;
    assign out_instr  = out_valid ? q_instr[head] : 32'h0;
    assign out_pc     = out_valid ? q_pc[head] : 32'h0;
    assign full       = q_count == FULL;
    assign pop        = out_valid && out_ready;
    assign push       = state == FETCH && fetch_en && !redirect_valid && (!full || pop);
    assign count_next = redirect_valid ? 3'd0 : q_count + {2'b00, push} - {2'b00, pop};

    // Redirect overrides everything; otherwise fetch_en=0 parks every state in IDLE.
    always_comb begin
        state_next = state;
        if (redirect_valid) state_next = fetch_en ? FETCH : IDLE;
        else if (!fetch_en) state_next = IDLE;
        else if (state == IDLE) state_next = FETCH;
        else if (state == FETCH && count_next == FULL && !pop) state_next = STALL;
        else if (state == STALL && pop) state_next = FETCH;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            q_count      <= 3'd0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            q_count      <= count_next;
            misalign_err <= redirect_valid && redirect_pc[1:0] != 2'b00;
            fetch_pc     <= redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? fetch_pc + 32'd4 : fetch_pc;
            head         <= redirect_valid ? '0 : head + AW'(pop);
            tail         <= redirect_valid ? '0 : tail + AW'(push);
        end
    end

    // Payload storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= imem_rd_instr;
            q_pc[tail]    <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus against a queue-level model of the fetch unit,
// checked every cycle plus hand-computed literal expectations.
module tb_fetch_unit;
    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n, fetch_en, redirect_valid, out_ready, out_valid, misalign_err;
    logic [31:0] imem_addr, imem_rd_instr, redirect_pc, out_instr, out_pc, key;
    logic [2:0]  q_count;
    int          total = 0, bad = 0;
    bit          chk_en = 1'b0;

    logic [63:0] mq[$];
    int          mode;
    logic [31:0] mpc;
    logic        mmis;

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_rd_instr(imem_rd_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .q_count(q_count), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;
    assign imem_rd_instr = imem_addr ^ key;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mode = 0;
        mpc  = RPC;
        mmis = 1'b0;
    endtask

    // mode: 0 idle, 1 fetching, 2 stalled on a full queue
    task automatic model_step();
        bit pop, push;
        pop  = mq.size() != 0 && out_ready;
        push = mode == 1 && fetch_en && !redirect_valid && (mq.size() < QD || pop);
        mmis = redirect_valid && redirect_pc[1:0] != 2'b00;
        if (pop) void'(mq.pop_front());
        if (redirect_valid) begin
            mq.delete();
            mpc  = {redirect_pc[31:2], 2'b00};
            mode = fetch_en ? 1 : 0;
        end else begin
            if (push) begin
                mq.push_back({mpc, mpc ^ key});
                mpc = mpc + 32'd4;
            end
            if (!fetch_en) mode = 0;
            else if (mode == 0) mode = 1;
            else if (mode == 1 && mq.size() == QD && !pop) mode = 2;
            else if (mode == 2 && pop) mode = 1;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("q_count", 32'(q_count), 32'(mq.size()));
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("imem_addr", imem_addr, mpc);
            check("misalign", 32'(misalign_err), 32'(mmis));
            if (mq.size() != 0) begin
                check("out_pc", out_pc, mq[0][63:32]);
                check("out_instr", out_instr, mq[0][31:0]);
            end
        end
    end

    initial begin
        reset_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; key = 32'h0;
        model_reset();
        chk_en = 1'b1;
        cyc(2);
        check("rst_addr", imem_addr, RPC);
        check("rst_valid", 32'(out_valid), 32'd0);
        // streaming with memory word = address
        reset_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        cyc(1); check("c1_valid", 32'(out_valid), 32'd0);
        cyc(1); check("c2_pc", out_pc, 32'h0); check("c2_instr", out_instr, 32'h0);
        cyc(1); check("c3_pc", out_pc, 32'h4);
        cyc(1); check("c4_pc", out_pc, 32'h8); check("c4_instr", out_instr, 32'h8);
        // fill to STALL with consumer blocked
        reset_n = 1'b0; model_reset(); #1;
        check("rstB_valid", 32'(out_valid), 32'd0);
        check("rstB_addr", imem_addr, RPC);
        reset_n = 1'b1; out_ready = 1'b0;
        cyc(2); check("B_q1", 32'(q_count), 32'd1);
        cyc(1); check("B_q2", 32'(q_count), 32'd2); check("B_addr8", imem_addr, 32'h8);
        cyc(2); check("B_hold_q", 32'(q_count), 32'd2); check("B_hold_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        cyc(1); check("B_pop_q", 32'(q_count), 32'd1); check("B_pop_pc", out_pc, 32'h4);
        out_ready = 1'b0;
        cyc(1); check("B_refill_q", 32'(q_count), 32'd2); check("B_refill_addr", imem_addr, 32'hC);
        // redirect with same-cycle pop
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        check("C_head", out_pc, 32'h4);
        cyc(1); redirect_valid = 1'b0;
        check("C_flush_q", 32'(q_count), 32'd0); check("C_addr", imem_addr, 32'h40);
        cyc(1); check("C_pc40", out_pc, 32'h40);
        // misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h43;
        cyc(1); redirect_valid = 1'b0;
        check("D_addr", imem_addr, 32'h40); check("D_mis1", 32'(misalign_err), 32'd1);
        cyc(1); check("D_mis0", 32'(misalign_err), 32'd0);
        // address wrap, with instruction word distinct from its PC
        key = 32'hDEAD_0000;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc(1); redirect_valid = 1'b0;
        cyc(1); check("E_pc", out_pc, 32'hFFFF_FFFC); check("E_instr", out_instr, 32'h2152_FFFC);
        cyc(1); check("E_wrap_pc", out_pc, 32'h0); check("E_wrap_instr", out_instr, 32'hDEAD_0000);
        // full queue survives fetch_en=0, then push+pop while full
        out_ready = 1'b0;
        cyc(3); check("F_full", 32'(q_count), 32'd2);
        fetch_en = 1'b0;
        cyc(2); check("F_noflush", 32'(q_count), 32'd2);
        fetch_en = 1'b1;
        cyc(1);
        out_ready = 1'b1;
        cyc(1); check("F_pushpop_q", 32'(q_count), 32'd2);
        cyc(2);
        fetch_en = 1'b0;
        cyc(3); check("F_drain", 32'(q_count), 32'd0);
        // redirect while idle stays idle
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc(1); redirect_valid = 1'b0;
        cyc(2); check("G_idle_q", 32'(q_count), 32'd0); check("G_idle_addr", imem_addr, 32'h100);
        // asynchronous reset with a full queue
        fetch_en = 1'b1; out_ready = 1'b0;
        cyc(4); check("H_full", 32'(q_count), 32'd2);
        #2; reset_n = 1'b0; model_reset(); #1;
        check("H_valid", 32'(out_valid), 32'd0);
        check("H_addr", imem_addr, RPC);
        check("H_q", 32'(q_count), 32'd0);
        check("H_pc", out_pc, 32'h0);
        check("H_instr", out_instr, 32'h0);
        reset_n = 1'b1; out_ready = 1'b1;
        cyc(4);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
